// File: rtl/ctrl_pkg.sv
// Shared control-word layout for the decode-to-writeback control pipeline.
// Latency: none (constants only).
// Backpressure: n/a.
package ctrl_pkg;

    // Default width of the decoded control word.
    localparam int CW_DEF = 19;

    // Bit positions of the individual decoder outputs in the control word.
    localparam int MEMTOREG_IDX = 0;
    localparam int MEMEN_IDX    = 1;
    localparam int ALUSRC_IDX   = 2;
    localparam int REGDST_IDX   = 3;
    localparam int REGWRITE_IDX = 4;
    localparam int JAL_IDX      = 5;
    localparam int JR_IDX       = 6;
    localparam int MEMWRITE_IDX = 7;
    localparam int ALUCTRL_LSB  = 8;
    localparam int ALUCTRL_MSB  = 15;
    // Bits [18:16] are spare.

    // A killed instruction (overflow, address error) must not write the
    // register file, so only regwrite is stripped.
    localparam logic [CW_DEF-1:0] KILL_MASK_DEF = CW_DEF'(1) << REGWRITE_IDX;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle of decode-side inputs, per-stage controls and per-stage outputs.
// Latency: n/a (wiring only).
// Backpressure: stall/flush/kill are per-stage hold/clear controls from the hazard unit.
interface ctrl_pipe_if
    import ctrl_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int CW     = CW_DEF
);
    logic [CW-1:0]        ctrl_d;
    logic                 valid_d;
    logic                 branch_d;
    logic [NSTAGE-1:0]    stall;
    logic [NSTAGE-1:0]    flush;
    logic [NSTAGE-1:0]    kill;
    logic [NSTAGE*CW-1:0] ctrl_q;
    logic [NSTAGE-1:0]    valid_q;
    logic [NSTAGE-1:0]    slot_q;
    logic                 stall_err;

    // Driver side: decoders plus hazard unit.
    modport master (
        output ctrl_d, valid_d, branch_d, stall, flush, kill,
        input  ctrl_q, valid_q, slot_q, stall_err
    );

    // Pipeline side.
    modport slave (
        input  ctrl_d, valid_d, branch_d, stall, flush, kill,
        output ctrl_q, valid_q, slot_q, stall_err
    );
endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register for a control word with valid and delay-slot bits.
// Latency: 1 cycle from upstream to output.
// Backpressure: flush > stall(hold) > upstream-stalled(bubble) > load; kill strips mask bits on load.
// Ports: clk/rst; flush/stall for this stage; up_stall/up_kill from the previous stage;
//        up_word/up_valid/up_slot upstream contents; word_q/valid_q/slot_q stage contents.
module ctrl_stage_reg
    import ctrl_pkg::*;
#(
    parameter int            CW        = CW_DEF,
    parameter logic [CW-1:0] KILL_MASK = CW'(KILL_MASK_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          stall,
    input  logic          up_stall,
    input  logic          up_kill,
    input  logic [CW-1:0] up_word,
    input  logic          up_valid,
    input  logic          up_slot,
    output logic [CW-1:0] word_q,
    output logic          valid_q,
    output logic          slot_q
);
    logic [CW-1:0] word_d;
    logic          valid_d;
    logic          slot_d;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        slot_d  = slot_q;
        if (flush) begin
            word_d  = '0;
            valid_d = 1'b0;
            slot_d  = 1'b0;
        end else if (stall) begin
            // hold
        end else if (up_stall) begin
            // Upstream is frozen and its word will move on later; taking it
            // now would duplicate the instruction.
            word_d  = '0;
            valid_d = 1'b0;
            slot_d  = 1'b0;
        end else begin
            word_d  = up_kill ? (up_word & ~KILL_MASK) : up_word;
            valid_d = up_valid;
            slot_d  = up_slot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            slot_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end
endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline from decode through NSTAGE stages (E, M, W, ...) with delay-slot and stall-error tracking.
// Latency: decode word appears at stage i after i+1 cycles when nothing stalls.
// Backpressure: per-stage stall holds, flush bubbles, stalled upstream feeds bubbles; stall_err flags a downstream stall without its upstream.
// Ports: clk, rst (async active-low), dp (slave modport: decode inputs, stage controls, stage outputs, stall_err).
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int            NSTAGE    = 3,
    parameter int            CW        = CW_DEF,
    parameter logic [CW-1:0] KILL_MASK = CW'(KILL_MASK_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    ctrl_pipe_if.slave    dp
);
    logic slot_pend_d, slot_pend_q;
    logic stall_err_d, stall_err_q;
    logic stall_bad;
    logic seen_free;

    logic [CW-1:0]     stage_word [NSTAGE];
    logic [NSTAGE-1:0] stage_valid;
    logic [NSTAGE-1:0] stage_slot;

    // The last stage's word never advances, so its kill has nothing to act on.
    logic unused_kill;
    assign unused_kill = dp.kill[NSTAGE-1];

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        logic          up_stall;
        logic          up_kill;
        logic [CW-1:0] up_word;
        logic          up_valid;
        logic          up_slot;

        if (i == 0) begin : g_head
            assign up_stall = 1'b0;
            assign up_kill  = 1'b0;
            assign up_word  = dp.ctrl_d;
            assign up_valid = dp.valid_d;
            assign up_slot  = slot_pend_q;
        end else begin : g_body
            assign up_stall = dp.stall[i-1];
            assign up_kill  = dp.kill[i-1];
            assign up_word  = stage_word[i-1];
            assign up_valid = stage_valid[i-1];
            assign up_slot  = stage_slot[i-1];
        end

        ctrl_stage_reg #(
            .CW        (CW),
            .KILL_MASK (KILL_MASK)
        ) u_reg (
            .clk      (clk),
            .rst      (rst),
            .flush    (dp.flush[i]),
            .stall    (dp.stall[i]),
            .up_stall (up_stall),
            .up_kill  (up_kill),
            .up_word  (up_word),
            .up_valid (up_valid),
            .up_slot  (up_slot),
            .word_q   (stage_word[i]),
            .valid_q  (stage_valid[i]),
            .slot_q   (stage_slot[i])
        );

        assign dp.ctrl_q[i*CW +: CW] = stage_word[i];
    end

    assign dp.valid_q   = stage_valid;
    assign dp.slot_q    = stage_slot;
    assign dp.stall_err = stall_err_q;

    // slot_pend remembers that the last real instruction taken from decode
    // was a branch, so the next real one is its delay slot. Bubbles do not
    // consume the slot.
    always_comb begin
        slot_pend_d = slot_pend_q;
        if (dp.flush[0]) begin
            slot_pend_d = 1'b0;
        end else if (!dp.stall[0] && dp.valid_d) begin
            slot_pend_d = dp.branch_d;
        end
    end

    // Legal stall vectors are a contiguous run of ones from stage 0; any
    // stalled stage above a free one is an error.
    always_comb begin
        stall_bad = 1'b0;
        seen_free = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (dp.stall[i] && seen_free) begin
                stall_bad = 1'b1;
            end
            if (!dp.stall[i]) begin
                seen_free = 1'b1;
            end
        end
        stall_err_d = stall_err_q | stall_bad;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_pend_q <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            slot_pend_q <= slot_pend_d;
            stall_err_q <= stall_err_d;
        end
    end
endmodule
